// File: rtl/riscv_uart_loader_pkg.sv
// Shared state encodings for the UART boot loader and its byte receiver.
package riscv_constants;

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } LOADER_STATE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } UART_RX_STATE;

endpackage

// File: rtl/riscv_uart_loader_if.sv
// RAM write port driven by the boot loader: one-cycle strobe, word-aligned byte address, little-endian data.
interface riscv_uart_loader_if;

  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;

  modport master (output ram_we, output ram_addr, output ram_wdata);
  modport slave  (input  ram_we, input  ram_addr, input  ram_wdata);

endinterface

// File: rtl/riscv_uart_loader_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte_valid_o or frame_err_o per frame.
module riscv_uart_rx
  import riscv_constants::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       x_reset,
  input  logic       uart_rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic         sync1_q, sync2_q;
  UART_RX_STATE state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]   bit_q, bit_d;
  logic [7:0]   sh_q, sh_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Re-check the line half a bit in; a short low pulse is treated as noise.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = sync2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          valid_d = sync2_q;
          err_d   = !sync2_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (x_reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_data_o  = sh_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/riscv_uart_loader.sv
// Boot loader: length-prefixed little-endian image over UART into RAM, holding the core in reset until done.
module riscv_uart_loader
  import riscv_constants::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH_WORDS  = 4096
) (
  input  logic                clk,
  input  logic                x_reset,
  input  logic                uart_rx,
  riscv_uart_loader_if.master ram,
  output logic                core_hold,
  output logic                load_done,
  output logic                load_err
);

  localparam int WIW = $clog2(DEPTH_WORDS) + 1;
  localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  riscv_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .x_reset      (x_reset),
    .uart_rx_i    (uart_rx),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .frame_err_o  (frame_err)
  );

  LOADER_STATE    state_q, state_d;
  logic [1:0]     byte_idx_q, byte_idx_d;
  logic [31:0]    len_q, len_d;
  logic [31:0]    asm_q, asm_d;
  logic [WIW-1:0] word_idx_q, word_idx_d;
  logic           we_q, we_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           hold_q, hold_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [31:0]    full_len;
  logic [WIW-1:0] word_next;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    len_d      = len_q;
    asm_d      = asm_q;
    word_idx_d = word_idx_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q | frame_err;
    full_len   = {byte_data, len_q[23:0]};
    word_next  = word_idx_q + WIW'(1);
    if (byte_valid) begin
      case (state_q)
        S_LEN: begin
          len_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            if (full_len == 32'd0) begin
              state_d = S_DONE;
            end else if (full_len > DEPTH32) begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          // Assemble separately so the RAM bus keeps the last written word between strobes.
          asm_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            wdata_d    = {byte_data, asm_q[23:0]};
            addr_d     = 32'({word_idx_q, 2'b00});
            word_idx_d = word_next;
            if (32'(word_next) == len_q) state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end
    hold_d = (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (x_reset) begin
      state_q    <= S_LEN;
      byte_idx_q <= 2'd0;
      len_q      <= 32'd0;
      asm_q      <= 32'd0;
      word_idx_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      len_q      <= len_d;
      asm_q      <= asm_d;
      word_idx_q <= word_idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ram.ram_we    = we_q;
  assign ram.ram_addr  = addr_q;
  assign ram.ram_wdata = wdata_q;
  assign core_hold     = hold_q;
  assign load_done     = done_q;
  assign load_err      = err_q;

endmodule

// File: tb/tb_riscv_uart_loader.sv
// Directed bench for riscv_uart_loader at CLKS_PER_BIT=4, DEPTH_WORDS=16.
module tb_riscv_uart_loader;
  import riscv_constants::*;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic x_reset;
  logic uart_rx;
  logic core_hold, load_done, load_err;

  riscv_uart_loader_if ram_bus ();

  riscv_uart_loader #(.CLKS_PER_BIT(CPB), .DEPTH_WORDS(16)) dut (
    .clk       (clk),
    .x_reset   (x_reset),
    .uart_rx   (uart_rx),
    .ram       (ram_bus),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always @(negedge clk) begin
    if (ram_bus.ram_we === 1'b1) begin
      wr_addr.push_back(ram_bus.ram_addr);
      wr_data.push_back(ram_bus.ram_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wa(input int i);
    return (i < wr_addr.size()) ? wr_addr[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] wd(input int i);
    return (i < wr_data.size()) ? wr_data[i] : 32'hxxxxxxxx;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic do_reset();
    x_reset = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    x_reset = 1'b0;
    @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    x_reset = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);

    // 1: reset state held for 100 cycles, then idle line after release
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("reset_flags", {28'd0, ram_bus.ram_we, core_hold, load_done, load_err}, 32'h4);
    end
    chk("reset_addr", ram_bus.ram_addr, 32'h0);
    chk("reset_wdata", ram_bus.ram_wdata, 32'h0);
    x_reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_flags", {28'd0, ram_bus.ram_we, core_hold, load_done, load_err}, 32'h4);
    chk("idle_writes", 32'(wr_addr.size()), 32'd0);

    // 2: two-word image
    do_reset();
    send_word(32'd2);
    chk("img2_hold_mid", {31'd0, core_hold}, 32'd1);
    send_word(32'h0000_0013);
    chk("img2_done_mid", {31'd0, load_done}, 32'd0);
    send_word(32'h0000_006F);
    chk("img2_count", 32'(wr_addr.size()), 32'd2);
    chk("img2_a0", wa(0), 32'h0);
    chk("img2_d0", wd(0), 32'h0000_0013);
    chk("img2_a1", wa(1), 32'h4);
    chk("img2_d1", wd(1), 32'h0000_006F);
    chk("img2_hold", {31'd0, core_hold}, 32'd0);
    chk("img2_done", {31'd0, load_done}, 32'd1);
    chk("img2_err", {31'd0, load_err}, 32'd0);
    chk("img2_bus_hold", ram_bus.ram_wdata, 32'h0000_006F);

    // 3: zero-length image, later bytes ignored
    do_reset();
    send_word(32'd0);
    chk("zero_done", {31'd0, load_done}, 32'd1);
    chk("zero_hold", {31'd0, core_hold}, 32'd0);
    send_word(32'h4433_2211);
    chk("zero_writes", 32'(wr_addr.size()), 32'd0);
    chk("zero_done_after", {31'd0, load_done}, 32'd1);

    // 4: framing error inside the data stream, byte resent
    do_reset();
    send_word(32'd1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b0);
    chk("ferr_flag", {31'd0, load_err}, 32'd1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    chk("ferr_count", 32'(wr_addr.size()), 32'd1);
    chk("ferr_addr", wa(0), 32'h0);
    chk("ferr_data", wd(0), 32'hDDCC_BBAA);
    chk("ferr_done", {31'd0, load_done}, 32'd1);

    // 5: one-cycle low glitch is not a start bit
    do_reset();
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_state", 32'(dut.state_q), 32'(S_LEN));
    chk("glitch_bidx", 32'(dut.byte_idx_q), 32'd0);
    chk("glitch_err", {31'd0, load_err}, 32'd0);
    send_word(32'd1);
    send_word(32'h1234_5678);
    chk("glitch_data", wd(0), 32'h1234_5678);
    chk("glitch_done", {31'd0, load_done}, 32'd1);

    // 6: reset after the second strobe of a 3-word image, then full reload
    do_reset();
    send_word(32'd3);
    send_word(32'hA000_0001);
    send_word(32'hA000_0002);
    chk("rst_mid_count", 32'(wr_addr.size()), 32'd2);
    x_reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_we", {31'd0, ram_bus.ram_we}, 32'd0);
    chk("rst_mid_hold", {31'd0, core_hold}, 32'd1);
    chk("rst_mid_addr", ram_bus.ram_addr, 32'h0);
    do_reset();
    send_word(32'd3);
    send_word(32'hB000_0001);
    send_word(32'hB000_0002);
    send_word(32'hB000_0003);
    chk("reload_count", 32'(wr_addr.size()), 32'd3);
    chk("reload_a0", wa(0), 32'h0);
    chk("reload_d0", wd(0), 32'hB000_0001);
    chk("reload_a1", wa(1), 32'h4);
    chk("reload_d1", wd(1), 32'hB000_0002);
    chk("reload_a2", wa(2), 32'h8);
    chk("reload_d2", wd(2), 32'hB000_0003);
    chk("reload_done", {31'd0, load_done}, 32'd1);

    // 7: length above capacity
    do_reset();
    send_word(32'd17);
    chk("big_err", {31'd0, load_err}, 32'd1);
    chk("big_hold", {31'd0, core_hold}, 32'd1);
    chk("big_done", {31'd0, load_done}, 32'd0);
    send_word(32'hDEAD_BEEF);
    chk("big_writes", 32'(wr_addr.size()), 32'd0);
    chk("big_hold_after", {31'd0, core_hold}, 32'd1);

    // 16 words exactly fits
    do_reset();
    send_word(32'd16);
    for (int i = 0; i < 16; i++) send_word(32'hC000_0000 + 32'(i));
    chk("full_count", 32'(wr_addr.size()), 32'd16);
    chk("full_last_a", wa(15), 32'h3C);
    chk("full_last_d", wd(15), 32'hC000_000F);
    chk("full_err", {31'd0, load_err}, 32'd0);
    chk("full_done", {31'd0, load_done}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
